vif_task_writer_rr: RTL and testbench
=====================================

# vif_task_writer_rr

Parametrised multi-channel producer for the `my_if` data/valid/ready interface. Each of `NCH` task-side channels pushes bytes into its own `DEPTH`-entry FIFO. A round-robin arbiter drains the FIFOs into a single registered valid/ready output stage that carries the source channel id. This is the sequential, backpressure-aware successor of the combinational task-driven interface writer. It sits between task-level stimulus/control logic and any `AccessOut`-style consumer.

## Interface
- `NCH`, 4: number of input channels; legal range 1..16.
- `DW`, 8: data width per channel.
- `DEPTH`, 4: entries per channel FIFO; power of two, ≥2.
- `CHW` (derived, not overridable): max(1, $clog2(NCH)).

Ports (name, direction, width, meaning):
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `task_en`  in  NCH  per-channel write request.
- `in_task_data`  in  NCH*DW  channel i data in bits [i*DW +: DW].
- `task_ready`  out  NCH  channel i FIFO not full.
- `ovf`  out  NCH  sticky flag: a write to channel i was dropped.
- `out_data`  out  DW  output data.
- `out_ch`  out  CHW  source channel of `out_data`.
- `out_valid`  out  1  output holds a word.
- `out_ready`  in  1  consumer accepts the word.
- `task_output_valid`  out  1  alias of `out_valid`, kept for compatibility with existing task-level checkers.

## Operation
- **Reset (async, `rst_n`=0):**
  - All FIFO counts and pointers are 0.
  - `out_valid`=0, `out_data`=0, `out_ch`=0, `ovf`=0.
  - The arbiter pointer `rr_ptr` is 0.
  - `task_ready` is all ones, because it is derived combinationally from the registered counts.
- **Push:**
  - Channel i accepts a write when `task_en[i] && task_ready[i]`.
  - `task_ready[i] = (count[i] != DEPTH)`, a function of registered state only. There is no pass-through: a full FIFO rejects a write even if it is popped in the same cycle.
- **Drop:** `task_en[i] && !task_ready[i]` discards the data and sets `ovf[i]`. `ovf[i]` clears only on reset.
- **Output load:**
  - When `!out_valid || out_ready`, the arbiter scans the non-empty channels starting at `rr_ptr`, ascending and wrapping at `NCH`. The first non-empty channel g is granted.
  - On a grant: the head of g is popped, `out_data` ← head of g, `out_ch` ← g, `out_valid` ← 1, and `rr_ptr` ← (g+1) mod NCH.
  - With no grant, `out_valid` ← 0 if `out_ready` is high, else it holds. `rr_ptr` is unchanged.
- **Backpressure:** while `out_valid && !out_ready`, `out_data`/`out_ch`/`out_valid` hold stable and no FIFO pops.
- **Simultaneous push and pop on one channel:** both happen and the count is unchanged. FIFO pointers wrap modulo `DEPTH`.
- **Ordering:** per-channel order is preserved. Cross-channel order is round-robin only.
- **`NCH`=1:** `out_ch` is constant 0 and the arbiter degenerates to "pop if non-empty".

## Timing
- **Latency:** a write accepted at edge k can appear on `out_valid`/`out_data` at edge k+1 at the earliest. The FIFO has no bypass.
- **Throughput:** one word per cycle with `out_ready` held high and any channel non-empty.
- **Combinational paths:** none from `out_ready` to `task_ready`, and none from `task_en` to any output.
- **Reset mid-operation:**
  - Outputs go to their reset values immediately (asynchronously).
  - Queued data is lost.
  - After `rst_n` rises, the first push is accepted on the next edge.

## Test plan
All scenarios use `NCH`=3, `DW`=8, `DEPTH`=4.

1. **Reset values.** Assert `rst_n`=0 mid-stream with `out_valid`=1 → `out_valid`/`out_data`/`out_ch`/`ovf` go to 0 without waiting for a clock edge, and `task_ready`=3'b111.
2. **Single-word latency.** With `out_ready`=1, push 8'hA5 on ch1 at edge 0 → `out_valid`=1, `out_data`=8'hA5, `out_ch`=1 after edge 1; `out_valid`=0 after edge 2.
3. **Round-robin order.** With `out_ready`=0, push ch0 {01,02}, ch1 {11}, ch2 {21,22} in one burst. Then hold `out_ready`=1 → the output sequence is 01(0), 11(1), 21(2), 02(0), 22(2).
4. **Full FIFO and drop.** With `out_ready`=0, push five words 30..34 on ch2 → `task_ready[2]`=0 after the 4th push, 34 is dropped, `ovf`=3'b100. On drain the output is 30, 31, 32, 33.
5. **Backpressure hold.** Present 8'h55 on ch0, then hold `out_ready`=0 for 3 cycles → `out_data`=8'h55 and `out_ch`=0 are stable for all 3 cycles, and ch0's count is unchanged.
6. **Push and pop same cycle.** With ch1 holding 2 entries, push on ch1 in the same cycle ch1 is granted → count stays 2 and the data order is preserved.

Source files
------------

// File: rtl/vif_task_writer_rr.sv
// Multi-channel byte producer: per-channel FIFOs drained by a round-robin arbiter
// into one registered valid/ready output stage tagged with the source channel.
module vif_task_writer_rr #(
    parameter int NCH   = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    task_en,
    input  logic [NCH*DW-1:0] in_task_data,
    output logic [NCH-1:0]    task_ready,
    output logic [NCH-1:0]    ovf,
    output logic [DW-1:0]     out_data,
    output logic [CHW-1:0]    out_ch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              task_output_valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DW-1:0]  mem    [NCH][DEPTH];
    logic [PW-1:0]  wr_ptr [NCH];
    logic [PW-1:0]  rd_ptr [NCH];
    logic [CW-1:0]  count  [NCH];
    logic [NCH-1:0] push;
    logic [NCH-1:0] pop;
    logic           load;
    logic           grant_valid;
    logic [CHW-1:0] grant;
    logic [CHW-1:0] rr_ptr;
    logic [CHW-1:0] sel;
    int             idx;

    assign task_output_valid = out_valid;
    assign load              = !out_valid || out_ready;

    // Ready depends on registered counts only, so a full FIFO never takes a word
    // even when it is being popped in the same cycle.
    always_comb begin
        task_ready = '0;
        push       = '0;
        pop        = '0;
        for (int i = 0; i < NCH; i++) begin
            task_ready[i] = (count[i] != CW'(DEPTH));
            push[i]       = task_en[i] && task_ready[i];
            pop[i]        = load && grant_valid && (int'(grant) == i);
        end
    end

    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        idx         = 0;
        sel         = '0;
        for (int off = 0; off < NCH; off++) begin
            idx = int'(rr_ptr) + off;
            if (idx >= NCH) idx = idx - NCH;
            sel = CHW'(idx);
            if (!grant_valid && (count[sel] != '0)) begin
                grant_valid = 1'b1;
                grant       = sel;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            ovf <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
                if (push[i] && !pop[i])
                    count[i] <= count[i] + CW'(1);
                else if (!push[i] && pop[i])
                    count[i] <= count[i] - CW'(1);
                if (task_en[i] && !task_ready[i]) ovf[i] <= 1'b1;
            end
        end
    end

    // Storage carries no reset; occupancy is tracked entirely by the counts.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= in_task_data[i*DW +: DW];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= '0;
        end else if (load) begin
            if (grant_valid) begin
                out_data  <= mem[grant][rd_ptr[grant]];
                out_ch    <= grant;
                out_valid <= 1'b1;
                rr_ptr    <= (int'(grant) == NCH - 1) ? '0 : grant + CHW'(1);
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vif_task_writer_rr.sv
// Directed and random bench for vif_task_writer_rr (NCH=3, DW=8, DEPTH=4) checked
// against a queue-based reference model of the channel FIFOs and output stage.
module tb_vif_task_writer_rr;

    logic        clk;
    logic        rst_n;
    logic [2:0]  task_en;
    logic [23:0] in_task_data;
    logic [2:0]  task_ready;
    logic [2:0]  ovf;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;
    logic        task_output_valid;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mq [3][$];
    logic        m_valid;
    logic [7:0]  m_data;
    int          m_ch;
    int          m_rr;
    logic [2:0]  m_ovf;
    logic [15:0] seen [$];

    vif_task_writer_rr #(.NCH(3), .DW(8), .DEPTH(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .task_en           (task_en),
        .in_task_data      (in_task_data),
        .task_ready        (task_ready),
        .ovf               (ovf),
        .out_data          (out_data),
        .out_ch            (out_ch),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .task_output_valid (task_output_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] model_ready();
        logic [2:0] r;
        for (int i = 0; i < 3; i++) r[i] = (mq[i].size() != 4);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) mq[i].delete();
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_ch    = 0;
        m_rr    = 0;
        m_ovf   = 3'b000;
    endtask

    // Advance the model by one clock using the inputs presented before the edge.
    task automatic model_step(input logic [2:0] en, input logic [23:0] data, input bit ordy);
        logic [2:0] rdy;
        int         g;
        rdy = model_ready();
        if (!m_valid || ordy) begin
            g = -1;
            for (int k = 0; k < 3; k++) begin
                if (g < 0 && mq[(m_rr + k) % 3].size() != 0) g = (m_rr + k) % 3;
            end
            if (g >= 0) begin
                m_data  = mq[g].pop_front();
                m_ch    = g;
                m_valid = 1'b1;
                m_rr    = (g + 1) % 3;
            end else begin
                m_valid = 1'b0;
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (en[i]) begin
                if (rdy[i]) mq[i].push_back(data[i*8 +: 8]);
                else        m_ovf[i] = 1'b1;
            end
        end
    endtask

    task automatic checkOutput();
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("task_output_valid", {31'd0, task_output_valid}, {31'd0, m_valid});
        chk("out_data", {24'd0, out_data}, {24'd0, m_data});
        chk("out_ch", {30'd0, out_ch}, m_ch);
        chk("ovf", {29'd0, ovf}, {29'd0, m_ovf});
        chk("task_ready", {29'd0, task_ready}, {29'd0, model_ready()});
    endtask

    // One cycle: drive, check combinational ready, record accepted words, clock, check.
    task automatic applyStimulus(input logic [2:0] en, input logic [23:0] data, input bit ordy);
        task_en      = en;
        in_task_data = data;
        out_ready    = ordy;
        #1;
        chk("task_ready_pre", {29'd0, task_ready}, {29'd0, model_ready()});
        if (out_valid && ordy) seen.push_back({6'd0, out_ch, out_data});
        model_step(en, data, ordy);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        model_reset();
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_seen(input string tag, input logic [15:0] exp []);
        chk({tag, "_len"}, seen.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < seen.size()) chk(tag, {16'd0, seen[i]}, {16'd0, exp[i]});
        end
        seen.delete();
    endtask

    initial begin
        logic [15:0] exp_rr [];
        logic [15:0] exp_full [];
        logic [15:0] exp_pp [];
        rst_n        = 1'b0;
        task_en      = '0;
        in_task_data = '0;
        out_ready    = 1'b0;
        model_reset();
        #3;
        checkOutput();
        chk("reset_ready", {29'd0, task_ready}, 32'h7);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single-word latency
        applyStimulus(3'b010, 24'h00A500, 1'b1);
        chk("lat_edge0_valid", {31'd0, out_valid}, 32'd0);
        applyStimulus(3'b000, 24'h000000, 1'b1);
        chk("lat_edge1_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_edge1_data", {24'd0, out_data}, 32'hA5);
        chk("lat_edge1_ch", {30'd0, out_ch}, 32'd1);
        applyStimulus(3'b000, 24'h000000, 1'b1);
        chk("lat_edge2_valid", {31'd0, out_valid}, 32'd0);

        // Round-robin order
        doReset();
        seen.delete();
        applyStimulus(3'b111, 24'h211101, 1'b0);
        applyStimulus(3'b101, 24'h220002, 1'b0);
        applyStimulus(3'b000, 24'h000000, 1'b0);
        applyStimulus(3'b000, 24'h000000, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(3'b000, 24'h000000, 1'b1);
        exp_rr = '{16'h0001, 16'h0111, 16'h0221, 16'h0002, 16'h0222};
        check_seen("rr_order", exp_rr);

        // Full FIFO, drop, and backpressure hold on the ch0 word
        doReset();
        applyStimulus(3'b001, 24'h000055, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(3'b100, {8'(8'h30 + i), 16'h0000}, 1'b0);
            if (i < 3) begin
                chk("bp_data", {24'd0, out_data}, 32'h55);
                chk("bp_ch", {30'd0, out_ch}, 32'd0);
                chk("bp_ch0_ready", {31'd0, task_ready[0]}, 32'd1);
            end
            if (i == 3) chk("full_ready2", {31'd0, task_ready[2]}, 32'd0);
        end
        chk("drop_ovf", {29'd0, ovf}, 32'h4);
        for (int i = 0; i < 6; i++) applyStimulus(3'b000, 24'h000000, 1'b1);
        exp_full = '{16'h0055, 16'h0230, 16'h0231, 16'h0232, 16'h0233};
        check_seen("full_drain", exp_full);

        // Asynchronous reset while a word is held
        applyStimulus(3'b001, 24'h000077, 1'b0);
        applyStimulus(3'b000, 24'h000000, 1'b0);
        chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", {31'd0, out_valid}, 32'd0);
        chk("async_data", {24'd0, out_data}, 32'd0);
        chk("async_ch", {30'd0, out_ch}, 32'd0);
        chk("async_ovf", {29'd0, ovf}, 32'd0);
        chk("async_ready", {29'd0, task_ready}, 32'h7);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Push and pop on ch1 in the same cycle
        seen.delete();
        applyStimulus(3'b010, 24'h00A000, 1'b0);
        applyStimulus(3'b010, 24'h00A100, 1'b0);
        applyStimulus(3'b010, 24'h00A200, 1'b0);
        applyStimulus(3'b010, 24'h00A300, 1'b1);
        chk("pp_ready1", {31'd0, task_ready[1]}, 32'd1);
        for (int i = 0; i < 4; i++) applyStimulus(3'b000, 24'h000000, 1'b1);
        exp_pp = '{16'h01A0, 16'h01A1, 16'h01A2, 16'h01A3};
        check_seen("pp_order", exp_pp);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            applyStimulus(3'($urandom_range(0, 7)), 24'($urandom),
                          ($urandom_range(0, 3) != 0));
        end
        seen.delete();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
